// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receive stage. The serial line passes through a
//                two-flop synchronizer, and an oversampling FSM samples it
//                near the centre of each bit. The FSM advances only on the
//                rx_enb oversample tick. The stage rejects short start
//                glitches and reports framing errors and overruns.
//
//  Ports       : i_clk      - system clock, rising edge
//                i_rst      - synchronous active-high reset
//                rx         - asynchronous serial line, idles high
//                rx_enb     - single-cycle oversample tick
//                rdy_clr    - host acknowledge, clears rdy and overrun
//                data_out   - last correctly framed byte
//                rdy        - new byte available (sticky until rdy_clr)
//                frame_err  - last completed frame had a low stop bit
//                overrun    - byte completed while rdy was still set
//                busy       - receiver is not idle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int SAMPLE_W   = $clog2(OVERSAMPLE)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       rx,
    input  logic       rx_enb,
    input  logic       rdy_clr,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Last sample index of the half start bit and of a full bit period.
    localparam logic [SAMPLE_W-1:0] c_half_last = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] c_bit_last  = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [SAMPLE_W-1:0] c_one       = SAMPLE_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SAMPLE_W-1:0] r_sample;
    logic [SAMPLE_W-1:0] w_sample_nxt;
    logic [2:0]          r_bitcnt;
    logic [2:0]          w_bitcnt_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic [7:0]          r_data_out;
    logic [7:0]          w_data_out_nxt;
    logic                r_rdy;
    logic                w_rdy_nxt;
    logic                r_frame_err;
    logic                w_frame_err_nxt;
    logic                r_overrun;
    logic                w_overrun_nxt;
    logic                r_rx_meta;
    logic                r_rx_s;
    logic                w_done_ok;
    logic                w_done_bad;

    // Two-flop synchronizer; reset to the idle (high) line level so that a
    // reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sample    <= '0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_data_out  <= 8'h00;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sample    <= w_sample_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_data_out  <= w_data_out_nxt;
            r_rdy       <= w_rdy_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state logic. Everything holds unless an oversample tick arrives.
    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_done_ok    = 1'b0;
        w_done_bad   = 1'b0;

        if (rx_enb) begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt  = START;
                        w_sample_nxt = '0;
                    end
                end

                START: begin
                    if (r_rx_s) begin
                        // Line went high before mid start bit: treat as noise.
                        w_state_nxt  = IDLE;
                        w_sample_nxt = '0;
                    end else if (r_sample == c_half_last) begin
                        // Half a bit in: later samples land on bit centres.
                        w_state_nxt  = DATA;
                        w_sample_nxt = '0;
                        w_bitcnt_nxt = 3'd0;
                    end else begin
                        w_sample_nxt = r_sample + c_one;
                    end
                end

                DATA: begin
                    if (r_sample == c_bit_last) begin
                        w_shift_nxt  = {r_rx_s, r_shift[7:1]};
                        w_sample_nxt = '0;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_state_nxt = STOP;
                        end
                    end else begin
                        w_sample_nxt = r_sample + c_one;
                    end
                end

                STOP: begin
                    if (r_sample == c_bit_last) begin
                        w_state_nxt  = IDLE;
                        w_sample_nxt = '0;
                        w_done_ok    = r_rx_s;
                        w_done_bad   = !r_rx_s;
                    end else begin
                        w_sample_nxt = r_sample + c_one;
                    end
                end

                default: begin
                    w_state_nxt  = IDLE;
                    w_sample_nxt = '0;
                end
            endcase
        end
    end

    // Host-side flags. A completing byte takes priority over rdy_clr; with
    // both present the byte is treated as read-pending but not an overrun.
    always_comb begin
        w_data_out_nxt  = r_data_out;
        w_rdy_nxt       = r_rdy;
        w_overrun_nxt   = r_overrun;
        w_frame_err_nxt = r_frame_err;

        if (w_done_ok) begin
            w_data_out_nxt  = r_shift;
            w_rdy_nxt       = 1'b1;
            w_overrun_nxt   = r_rdy && !rdy_clr;
            w_frame_err_nxt = 1'b0;
        end else begin
            if (rdy_clr) begin
                w_rdy_nxt     = 1'b0;
                w_overrun_nxt = 1'b0;
            end
            if (w_done_bad) begin
                w_frame_err_nxt = 1'b1;
            end
        end
    end

    assign data_out  = r_data_out;
    assign rdy       = r_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver. Frames are described
//                as bit sequences and driven one oversample tick at a time.
//                Expected host-side outputs come from a frame-level model:
//                the byte, its stop bit and any host acknowledge decide the
//                result of each frame.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int OS          = 16;
    localparam int FRAME_TICKS = 10 * OS;
    // The stop bit is judged at its centre, half a bit into it.
    localparam int DONE_TICK   = 9 * OS + OS / 2;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       rx;
    logic       rx_enb;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the host-visible state.
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_ovr;
    logic       exp_ferr;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .rx       (rx),
        .rx_enb   (rx_enb),
        .rdy_clr  (rdy_clr),
        .data_out (data_out),
        .rdy      (rdy),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data"},  data_out,            exp_data);
        chk({tag, ".rdy"},   {7'd0, rdy},         {7'd0, exp_rdy});
        chk({tag, ".ovr"},   {7'd0, overrun},     {7'd0, exp_ovr});
        chk({tag, ".ferr"},  {7'd0, frame_err},   {7'd0, exp_ferr});
    endtask

    // One oversample tick carrying the given line level. Called at a falling
    // edge; the line is set first and held at least two clocks before the
    // tick so the synchronizer output reflects it. Returns at the falling
    // edge right after the tick.
    task automatic tick(input logic line, input logic clr);
        rx      = line;
        rx_enb  = 1'b0;
        rdy_clr = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge i_clk);
        rx_enb  = 1'b1;
        rdy_clr = clr;
        @(negedge i_clk);
        rx_enb  = 1'b0;
        rdy_clr = 1'b0;
    endtask

    // Line level during tick i of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input logic stop_ok, input int i);
        int bitno;
        bitno = i / OS;
        if (bitno == 0)      return 1'b0;
        else if (bitno <= 8) return b[bitno-1];
        else                 return stop_ok;
    endfunction

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
    endtask

    task automatic pulse_clr(input string tag);
        rdy_clr = 1'b1;
        @(negedge i_clk);
        rdy_clr = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
        chk_all(tag);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_ok,
                              input logic clr_at_done);
        for (int i = 0; i < FRAME_TICKS; i++) begin
            tick(frame_bit(b, stop_ok, i), (i == DONE_TICK) ? clr_at_done : 1'b0);
            if (i == DONE_TICK - 1) begin
                chk({tag, ".busy_pre"}, {7'd0, busy}, 8'd1);
                chk({tag, ".rdy_pre"},  {7'd0, rdy},  {7'd0, exp_rdy});
            end
            if (i == DONE_TICK) begin
                if (stop_ok) begin
                    exp_ovr  = exp_rdy && !clr_at_done;
                    exp_rdy  = 1'b1;
                    exp_data = b;
                    exp_ferr = 1'b0;
                end else begin
                    exp_ferr = 1'b1;
                    if (clr_at_done) begin
                        exp_rdy = 1'b0;
                        exp_ovr = 1'b0;
                    end
                end
                chk({tag, ".busy_done"}, {7'd0, busy}, 8'd0);
                chk_all(tag);
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        logic       clr;

        i_rst   = 1'b1;
        rx      = 1'b1;
        rx_enb  = 1'b0;
        rdy_clr = 1'b0;
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        chk_all("reset");
        chk("reset.busy", {7'd0, busy}, 8'd0);
        idle_ticks(4);

        // Clean byte.
        send_frame("a5", 8'hA5, 1'b1, 1'b0);
        pulse_clr("a5_clr");

        // Short low glitch on an idle line.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        chk("glitch.busy_mid", {7'd0, busy}, 8'd1);
        tick(1'b1, 1'b0);
        chk("glitch.busy_end", {7'd0, busy}, 8'd0);
        chk_all("glitch");

        // Low stop bit: framing error, previous data kept.
        send_frame("3c_bad", 8'h3C, 1'b0, 1'b0);
        idle_ticks(2);

        // Back-to-back bytes without acknowledge.
        send_frame("11", 8'h11, 1'b1, 1'b0);
        send_frame("22", 8'h22, 1'b1, 1'b0);
        pulse_clr("22_clr");

        // Acknowledge on the very cycle the second byte completes.
        send_frame("33", 8'h33, 1'b1, 1'b0);
        send_frame("44", 8'h44, 1'b1, 1'b1);

        // Break: the line stays low through the stop bit, then re-triggers.
        send_frame("break", 8'h00, 1'b0, 1'b0);
        chk("break.retrigger", {7'd0, busy}, 8'd1);
        tick(1'b1, 1'b0);
        chk("break.reject", {7'd0, busy}, 8'd0);
        idle_ticks(1);

        // Reset in the middle of bit 4 of 8'hFF.
        for (int i = 0; i < 5 * OS + OS / 2; i++) tick(frame_bit(8'hFF, 1'b1, i), 1'b0);
        chk("midrst.busy_pre", {7'd0, busy}, 8'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        chk_all("midrst");
        chk("midrst.busy", {7'd0, busy}, 8'd0);
        idle_ticks(3);
        send_frame("5a", 8'h5A, 1'b1, 1'b0);

        // Randomized frames, stop bits, acknowledges and gaps.
        for (int k = 0; k < 16; k++) begin
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 3) == 0);
            send_frame("rand", b, ok, clr);
            if (!ok) idle_ticks($urandom_range(1, 3));
            else     idle_ticks($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) pulse_clr("rand_clr");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage, 8N1 framing (1 start, 8 data LSB-first, 1 stop).
- Consumes the serial line driven by the team's UART transmitter and presents received bytes to the host side.
- Samples the line on a shared oversampling tick from the baud generator. Mid-bit sampling, glitch rejection, framing-error and overrun reporting.

Parameters:
- OVERSAMPLE, 16: rx_enb ticks per bit period. Power of two, minimum 4.
- SAMPLE_W, $clog2(OVERSAMPLE): width of the sample counter. Derived; never overridden.

Ports:
- i_clk, input, 1: system clock; all logic on the rising edge.
- i_rst, input, 1: reset, synchronous, active-high; clock i_clk.
- rx, input, 1: asynchronous serial line; idles high.
- rx_enb, input, 1: single-cycle oversample tick; OVERSAMPLE ticks per bit.
- rdy_clr, input, 1: single-cycle pulse; host acknowledges data_out.
- data_out, output, 8: last correctly framed byte.
- rdy, output, 1: new byte available; sticky until rdy_clr.
- frame_err, output, 1: last frame had stop bit = 0.
- overrun, output, 1: byte completed while rdy was still 1; sticky until rdy_clr.
- busy, output, 1: high whenever state != IDLE (combinational).

Behaviour:
Reset values (i_rst high at a clock edge):
- state = IDLE, data_out = 8'h00, rdy = 0, frame_err = 0, overrun = 0, busy = 0.
- Sample counter and bit counter = 0; shift register = 8'h00.
- Both synchronizer flops = 1.
- Reset overrides everything, including mid-frame: the frame in progress is discarded and no flags are set.

Synchronizer:
- rx passes through 2 flops to give rx_s; the FSM uses only rx_s.
- Sampling latency is 2 clocks.

FSM: all counting happens only on cycles with rx_enb = 1. With rx_enb = 0 the FSM holds.
- IDLE: on a tick with rx_s = 0, go to START, sample = 0.
- START: on each tick, if rx_s = 1, return to IDLE (glitch reject, no flags). Otherwise sample++. On the tick where sample == OVERSAMPLE/2-1 with rx_s still 0, go to DATA with sample = 0, bitcnt = 0. This aligns sampling to the bit centre.
- DATA: on each tick, sample++. On the tick where sample == OVERSAMPLE-1:
  - shift = {rx_s, shift[7:1]} (LSB first), sample = 0, bitcnt++.
  - When bitcnt == 7 on this tick, go to STOP.
- STOP: on each tick, sample++. On the tick where sample == OVERSAMPLE-1, go to IDLE and:
  - if rx_s = 1: data_out = shift, rdy = 1, frame_err = 0, and overrun = 1 if rdy was already 1. data_out is overwritten either way.
  - if rx_s = 0: frame_err = 1; data_out, rdy and overrun are unchanged.

Flag rules:
- rdy and the data_out update happen on the clock edge of the completing tick (latency 0 after that tick).
- rdy_clr clears rdy and overrun. frame_err is held until the next completed frame.
- If rdy_clr and a byte completion land in the same cycle, the set wins: rdy = 1 and overrun = 0.
- rdy_clr has no effect on the FSM.

Boundary conditions:
- A new start bit is accepted in the tick immediately after the return to IDLE; back-to-back frames need no gap.
- A line held low (break) produces frame_err = 1, then a re-trigger once the FSM is back in IDLE.
- Counter wrap is not permitted: sample is reset explicitly at every transition.

Test Plan:
1. Send 8'hA5 at 16 ticks/bit with a correct stop bit -> data_out = 8'hA5, rdy = 1, frame_err = 0, overrun = 0, busy = 0 after the stop-bit midpoint tick.
2. Low pulse of 3 ticks on an idle line -> FSM returns to IDLE, rdy = 0, frame_err = 0, busy back to 0.
3. Send 8'h3C with stop bit = 0 -> frame_err = 1, rdy stays 0, data_out keeps its previous value.
4. Send 8'h11 then 8'h22 back-to-back without rdy_clr -> data_out = 8'h22, rdy = 1, overrun = 1. Then pulse rdy_clr -> rdy = 0, overrun = 0.
5. Assert rdy_clr on the exact cycle the second byte completes -> rdy = 1, overrun = 0.
6. Assert i_rst during bit 4 of 8'hFF -> all outputs 0 on the next cycle. A following 8'h5A is received cleanly.
